uart_tx_scheduler: RTL

// Sequences and arbitrates the UART transmitter's load/send/data controls between two requesters:
// the manual switch/button path and the continuous burst path that drains TXBUF byte by byte.

---
 rtl/uart_tx_scheduler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
`timescale 1ns/1ps
// uart_tx_scheduler
// Arbitrates the UART transmitter controls between the manual switch/button
// requester and the burst requester that drains the transmit buffer one byte
// at a time. Sequencing advances only on baud_tick; all outputs are registered.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   baud_tick    one-clk enable at the baud rate
//   manual_load  manual requester: load request
//   manual_send  manual requester: send request
//   manual_data  manual requester: byte to load
//   burst_req    level; a burst starts on its rising edge (sampled on baud_tick)
//   burst_len    bytes in the burst, clamped to DEPTH; 0 is ignored
//   tx_load      to transmitter: load / discard head byte
//   tx_send      to transmitter: transmit head byte
//   tx_data      to transmitter: byte to load
//   busy         high whenever the scheduler is not idle
//   done         one-clk pulse when the last burst byte has been popped
//   bytes_sent   bytes completed in the current or last burst
module uart_tx_scheduler #(
  parameter int DEPTH       = 4,
  parameter int FRAME_TICKS = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic       manual_load,
  input  logic       manual_send,
  input  logic [7:0] manual_data,
  input  logic       burst_req,
  input  logic [2:0] burst_len,
  output logic       tx_load,
  output logic       tx_send,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [2:0] bytes_sent
);

  localparam int             TW        = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(FRAME_TICKS - 1);
  localparam logic [2:0]     DEPTH_3   = 3'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    ADVANCE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tick_cnt, tick_cnt_nxt;
  logic [2:0]      byte_cnt, byte_cnt_nxt;
  logic [2:0]      len, len_nxt;
  logic [2:0]      len_clamped;
  logic            req_prev;
  logic            start;
  logic            load_nxt, send_nxt, done_nxt;
  logic [7:0]      data_nxt;

  // A zero-length request never leaves IDLE, so it is folded into start.
  always_comb begin
    len_clamped = (burst_len > DEPTH_3) ? DEPTH_3 : burst_len;
    start       = baud_tick && burst_req && !req_prev && (len_clamped != 3'd0);
  end

  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    byte_cnt_nxt = byte_cnt;
    len_nxt      = len;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = SEND;
          tick_cnt_nxt = '0;
          byte_cnt_nxt = 3'd0;
          len_nxt      = len_clamped;
        end
      end
      SEND: begin
        if (baud_tick) begin
          if (tick_cnt == TICK_LAST) begin
            state_nxt    = ADVANCE;
            tick_cnt_nxt = '0;
          end else begin
            tick_cnt_nxt = tick_cnt + 1'b1;
          end
        end
      end
      ADVANCE: begin
        if (baud_tick) begin
          byte_cnt_nxt = byte_cnt + 3'd1;
          tick_cnt_nxt = '0;
          if ((byte_cnt + 3'd1) < len) begin
            state_nxt = SEND;
          end else begin
            state_nxt = HOLD;
            done_nxt  = 1'b1;
          end
        end
      end
      HOLD: begin
        // Wait for burst_req to fall so a held request cannot re-trigger.
        if (baud_tick && !burst_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered values line up
  // with the state they describe; manual inputs only pass through in IDLE.
  always_comb begin
    load_nxt = 1'b0;
    send_nxt = 1'b0;
    data_nxt = 8'h00;
    case (state_nxt)
      IDLE: begin
        load_nxt = manual_load;
        send_nxt = manual_send;
        data_nxt = manual_data;
      end
      SEND:    send_nxt = 1'b1;
      ADVANCE: load_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      byte_cnt <= 3'd0;
      len      <= 3'd0;
      req_prev <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_cnt_nxt;
      byte_cnt <= byte_cnt_nxt;
      len      <= len_nxt;
      if (baud_tick) req_prev <= burst_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_load <= 1'b0;
      tx_send <= 1'b0;
      tx_data <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      tx_load <= load_nxt;
      tx_send <= send_nxt;
      tx_data <= data_nxt;
      busy    <= (state_nxt != IDLE);
      done    <= done_nxt;
    end
  end

  assign bytes_sent = byte_cnt;

endmodule
